// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch controller that feeds a UART transmitter
// through its transmitir/busy handshake, so bursts of key presses are not lost
// while a frame is on the line.
// Optional feature macro: UART_TX_QUEUE_DROP_CNT_EN adds a saturating 8-bit
// count of dropped writes (drop_cnt), cleared together with overflow by ovf_clr.
module uart_tx_queue #(
    parameter int DEPTH        = 8,
    parameter int AW           = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    output logic [7:0]    drop_cnt,
`endif
    input  logic          ovf_clr,
    output logic [7:0]    dato_tx,
    output logic          transmitir,
    input  logic          busy,
    output logic          timeout
);

    localparam int             TW         = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TCNT_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [AW:0]    LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      dato_tx_q, dato_tx_d;
    logic            transmitir_q, transmitir_d;
    logic            timeout_q, timeout_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            push, pop, drop;

    logic [7:0]      mem [DEPTH];

    // Storage array: no reset, a reset simply empties it through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Launch FSM: decides when to pop the head byte and supervises the handshake.
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        pop          = 1'b0;
        transmitir_d = 1'b0;
        timeout_d    = 1'b0;
        dato_tx_d    = dato_tx_q;
        case (state_q)
            IDLE: begin
                if (!empty_q && !busy) begin
                    pop          = 1'b1;
                    dato_tx_d    = mem[rd_ptr_q];
                    transmitir_d = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                tcnt_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (tcnt_q == TCNT_LAST) begin
                    // Transmitter never acknowledged: drop this byte, no retry.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a write into a full queue survives only if a pop frees a slot.
    always_comb begin
        push       = wr_en && (!full_q || pop);
        drop       = wr_en && full_q && !pop;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW + 1)'(1);
        end
        full_d     = (level_d == LEVEL_FULL);
        empty_d    = (level_d == '0);
        overflow_d = ovf_clr ? 1'b0 : (drop ? 1'b1 : overflow_q);
    end

`ifdef UART_TX_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a clear wins over a same-cycle drop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = 8'h00;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            dato_tx_q    <= 8'h00;
            transmitir_q <= 1'b0;
            timeout_q    <= 1'b0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            dato_tx_q    <= dato_tx_d;
            transmitir_q <= transmitir_d;
            timeout_q    <= timeout_d;
            tcnt_q       <= tcnt_d;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign dato_tx    = dato_tx_q;
    assign transmitir = transmitir_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: a table of cycle vectors for the single-byte
// launch, then hand-written sequences for fill/overflow, timeout, full-queue
// push-with-pop and reset during a frame. The transmitter is modelled inline.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int BT    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    dato_tx;
    logic          transmitir;
    logic          busy;
    logic          timeout;
`ifdef UART_TX_QUEUE_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
`ifdef UART_TX_QUEUE_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .ovf_clr    (ovf_clr),
        .dato_tx    (dato_tx),
        .transmitir (transmitir),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_data;
        logic        busy;
        logic        ovf_clr;
        logic        exp_tx;
        logic [7:0]  exp_dato;
        logic [3:0]  exp_level;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (transmitir !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({name, "_launch"}, 32'(transmitir), 32'd1);
    endtask

    // Transmitter model: accept a launch, raise busy, hold it, then release.
    task automatic serve(input string name, input logic [7:0] exp, input int hold);
        int extra = 0;
        wait_launch(name);
        chk({name, "_dato"}, 32'(dato_tx), 32'(exp));
        step();
        chk({name, "_pulse"}, 32'(transmitir), 32'd0);
        busy = 1'b1;
        step();
        for (int i = 0; i < hold; i++) begin
            step();
            if (transmitir === 1'b1) extra++;
        end
        chk({name, "_quiet"}, 32'(extra), 32'd0);
        chk({name, "_hold"}, 32'(dato_tx), 32'(exp));
        busy = 1'b0;
        step();
    endtask

    task automatic quiet(input string name, input int cycles);
        int extra = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (transmitir === 1'b1) extra++;
        end
        chk({name, "_nolaunch"}, 32'(extra), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        int to_at;

        //                we    data   busy  clr   tx    dato   lvl   emp   ful   ovf   to
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        busy    = 1'b0;
        ovf_clr = 1'b0;
        #23;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_dato", 32'(dato_tx), 32'd0);
        chk("rst_tx", 32'(transmitir), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Test 1: single byte, table-driven cycle by cycle.
        for (int i = 0; i < 5; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            busy    = vecs[i].busy;
            ovf_clr = vecs[i].ovf_clr;
            step();
            chk($sformatf("t1_r%0d_tx", i), 32'(transmitir), 32'(vecs[i].exp_tx));
            chk($sformatf("t1_r%0d_dato", i), 32'(dato_tx), 32'(vecs[i].exp_dato));
            chk($sformatf("t1_r%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("t1_r%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("t1_r%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("t1_r%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("t1_r%0d_to", i), 32'(timeout), 32'(vecs[i].exp_timeout));
        end
        wr_en = 1'b0;
        quiet("t1_busy", 99);
        busy = 1'b0;
        step();
        // Back in IDLE: a fresh byte must launch with the minimum latency.
        wr_en   = 1'b1;
        wr_data = 8'h42;
        step();
        wr_en = 1'b0;
        step();
        chk("t1_idle_tx", 32'(transmitir), 32'd1);
        serve("t1_idle", 8'h42, 2);

        // Test 2: fill with the transmitter busy.
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h30 + 8'(i);
            step();
            chk($sformatf("t2_level%0d", i), 32'(level), 32'(i + 1));
        end
        wr_en = 1'b0;
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_tx_blocked", 32'(transmitir), 32'd0);

        // Test 3: overflow on a full queue.
        wr_en   = 1'b1;
        wr_data = 8'h58;
        step();
        wr_en = 1'b0;
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        chk("t3_level", 32'(level), 32'd8);
`ifdef UART_TX_QUEUE_DROP_CNT_EN
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        step();
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
`ifdef UART_TX_QUEUE_DROP_CNT_EN
        chk("t3_drop_clr", 32'(drop_cnt), 32'd0);
`endif

        // Test 2 continued: drain in order once busy is released.
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            serve($sformatf("t2_drain%0d", k), 8'h30 + 8'(k), 3);
        end
        chk("t2_empty", 32'(empty), 32'd1);
        quiet("t3_no58", 10);

        // Test 4: launch never acknowledged.
        wr_en   = 1'b1;
        wr_data = 8'h45;
        step();
        wr_data = 8'h46;
        step();
        wr_en = 1'b0;
        chk("t4_launch45", 32'(transmitir), 32'd1);
        chk("t4_dato45", 32'(dato_tx), 32'h45);
        chk("t4_level", 32'(level), 32'd1);
        step();
        chk("t4_launch_end", 32'(transmitir), 32'd0);
        to_at = -1;
        for (int k = 1; k <= BT; k++) begin
            step();
            if (timeout === 1'b1 && to_at < 0) to_at = k;
        end
        chk("t4_to_at", 32'(to_at), 32'(BT));
        step();
        chk("t4_to_once", 32'(timeout), 32'd0);
        serve("t4_next", 8'h46, 2);
        quiet("t4_noretry", 20);

        // Test 5: push on the same cycle as the pop from a full queue.
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h60 + 8'(i);
            step();
        end
        chk("t5_full", 32'(level), 32'd8);
        busy    = 1'b0;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        chk("t5_level", 32'(level), 32'd8);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_tx", 32'(transmitir), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            serve($sformatf("t5_drain%0d", k), 8'h60 + 8'(k), 2);
        end
        serve("t5_last", 8'h5A, 2);
        chk("t5_empty", 32'(empty), 32'd1);
        quiet("t5_done", 10);

        // Test 6: reset while a frame is in progress.
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h71 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("t6_level3", 32'(level), 32'd3);
        busy = 1'b0;
        step();
        chk("t6_launch", 32'(transmitir), 32'd1);
        step();
        busy = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_tx", 32'(transmitir), 32'd0);
        chk("t6_rst_dato", 32'(dato_tx), 32'd0);
        #2;
        rst_n = 1'b1;
        busy  = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (transmitir === 1'b1 || level !== '0) extra++;
        end
        chk("t6_after_rst", 32'(extra), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h7E;
        step();
        wr_en = 1'b0;
        step();
        chk("t6_new_tx", 32'(transmitir), 32'd1);
        serve("t6_new", 8'h7E, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO plus launch controller between the key-capture/ASCII conversion logic and the UART transmitter.
- Accepts ASCII bytes as single-cycle write strobes.
- Stores up to DEPTH bytes.
- Feeds the transmitter one byte at a time using its transmitir/busy handshake, so rapid key presses are not lost while a frame is in flight.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- AW, 3, pointer width = log2(DEPTH).
- BUSY_TIMEOUT, 16, cycles to wait for busy to rise after a launch before abandoning that byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_data  input  8  ASCII byte to enqueue.
- wr_en  input  1  one-cycle write strobe.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  AW+1  current number of stored entries.
- overflow  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  clears overflow; has priority over a same-cycle set.
- dato_tx  output  8  byte presented to the UART transmitter.
- transmitir  output  1  one-cycle launch pulse to the UART transmitter.
- busy  input  1  UART transmitter busy (frame in progress).
- timeout  output  1  one-cycle pulse when a launch was abandoned.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pointers and level go to 0; empty=1, full=0.
  - overflow=0, dato_tx=8'h00, transmitir=0, timeout=0.
  - FSM goes to IDLE and the timeout counter to 0.
  - A reset mid-frame discards all queued bytes and the byte in flight.
- All outputs are registered.
- Write rules:
  - wr_en=1 and full=0: store wr_data at the write pointer, increment the pointer (wraps modulo DEPTH), level+1.
  - wr_en=1 and full=1 with no pop that cycle: byte dropped, overflow set next edge.
  - wr_en=1 and full=1 with a pop that cycle: write accepted; level stays DEPTH.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
- FSM states:
  - IDLE:
    - If empty=0 and busy=0: at the next edge load dato_tx from the head entry, pop it (read pointer+1, level-1), set transmitir=1, go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH (lasts exactly 1 cycle): transmitir=1. Next edge: transmitir=0, clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - busy=1: go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse timeout=1 for one cycle and return to IDLE; the byte is not retried.
  - WAIT_DONE: on busy=0, go to IDLE.
- Latency:
  - A byte written at edge N into an empty queue with the transmitter idle has transmitir=1 during the cycle after edge N+1.
  - Back-to-back bytes: the next launch comes no sooner than 1 cycle after busy falls.
- dato_tx holds stable from LAUNCH until the next launch. It changes only on a launch.
- busy=1 while in IDLE blocks launches; it covers external or other-source use of the transmitter.
- level ranges 0..DEPTH; full = (level==DEPTH), empty = (level==0).

Optional Feature:
- Macro: UART_TX_QUEUE_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [7:0]: count of dropped writes, saturating at 8'hFF, reset to 0.
  - ovf_clr also clears it; ovf_clr has priority over a same-cycle increment.
- Undefined:
  - Port and counter are absent.
  - Only the sticky overflow flag reports drops.

Test Plan:
1. Reset, then write 8'h41 once with busy=0; model busy rising 2 cycles after transmitir and staying high 100 cycles.
   - Required: transmitir is a single 1-cycle pulse with dato_tx=8'h41.
   - Required: level goes 1 then 0.
   - Required: returns to IDLE after busy falls.
2. Write 8'h30..8'h37 on consecutive cycles with busy held high.
   - Required: level=8, full=1.
   - Required: after busy is released, 8 launches occur in order 8'h30..8'h37, each after the prior busy falls.
3. With the FIFO full and busy high, write 8'h58.
   - Required: overflow=1 next cycle, level stays 8, 8'h58 never appears on dato_tx.
   - Required: ovf_clr=1 clears overflow.
   - Required with the macro defined: drop_cnt=1, then 0 after ovf_clr.
4. Write 8'h45 with busy tied 0.
   - Required: timeout pulses exactly BUSY_TIMEOUT cycles after the end of LAUNCH.
   - Required: the next queued byte launches afterwards, with no retry of 8'h45.
5. At level=8 in IDLE with busy=0, assert wr_en with 8'h5A on the cycle the launch pop occurs.
   - Required: the write is accepted, level stays 8, overflow stays 0.
   - Required: 8'h5A is the last byte sent.
6. Queue 3 bytes and assert rst_n=0 during WAIT_DONE.
   - Required: empty=1, level=0, transmitir=0, dato_tx=8'h00 immediately.
   - Required: no further launches after reset release until new writes.
